// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state type, the NOP word and the base RV32I opcodes.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [31:0] NOP    = 32'h0000_0013;

   localparam logic [6:0]  OP     = 7'b0110011;
   localparam logic [6:0]  LOAD   = 7'b0000011;
   localparam logic [6:0]  OP_IMM = 7'b0010011;
   localparam logic [6:0]  STORE  = 7'b0100011;
   localparam logic [6:0]  BRANCH = 7'b1100011;
   localparam logic [6:0]  JAL    = 7'b1101111;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: instruction-memory request/response, decode handoff and redirect.
// The master modport is the fetch unit side; slave is memory/decode/branch side.
interface fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [6:0]  if_opcode;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
      input  imem_rvalid, imem_rdata, if_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode,
      output imem_rvalid, imem_rdata, if_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-pc selection.
// A redirect always wins over sequential advance; wraps modulo 2^32.
module fetch_pc_gen
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic [31:0] next_pc
);

   always_comb begin
      next_pc = pc;
      if (redirect) begin
         next_pc = word_align(redirect_pc);
      end else if (advance) begin
         next_pc = pc + 32'd4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= word_align(RESET_PC);
      end else begin
         pc <= next_pc;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit with redirect support.
// state | meaning
// FETCH | request at pc outstanding (req low only for the first cycle out of reset)
// HOLD  | fetched word presented to decode, no request outstanding
// DRAIN | stale request from before a redirect still in flight, response dropped
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic     clk,
   input  logic     rst,
   fetch_if.master  bus
);

   state_t      state;
   logic        req_q;
   logic [31:0] addr_q;
   logic        valid_q;
   logic [31:0] instr_q;
   logic [31:0] if_pc_q;
   logic        advance;
   logic [31:0] pc;
   logic [31:0] next_pc;

   assign advance = (state == FETCH) && req_q && bus.imem_rvalid && !bus.redirect_valid;

   fetch_pc_gen #(
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk         (clk),
      .rst         (rst),
      .advance     (advance),
      .redirect    (bus.redirect_valid),
      .redirect_pc (bus.redirect_pc),
      .pc          (pc),
      .next_pc     (next_pc)
   );

   // addr_q is loaded from next_pc whenever a new request is launched, so a
   // redirect in the same cycle steers the launch directly to the target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= FETCH;
         req_q   <= 1'b0;
         addr_q  <= word_align(RESET_PC);
         valid_q <= 1'b0;
         instr_q <= 32'h0;
         if_pc_q <= 32'h0;
      end else begin
         case (state)
            FETCH: begin
               if (!req_q) begin
                  req_q  <= 1'b1;
                  addr_q <= next_pc;
               end else if (bus.imem_rvalid) begin
                  if (bus.redirect_valid) begin
                     addr_q <= next_pc;
                  end else begin
                     instr_q <= bus.imem_rdata;
                     if_pc_q <= pc;
                     valid_q <= 1'b1;
                     req_q   <= 1'b0;
                     state   <= HOLD;
                  end
               end else if (bus.redirect_valid) begin
                  state <= DRAIN;
               end
            end
            HOLD: begin
               if (bus.redirect_valid || bus.if_ready) begin
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  addr_q  <= next_pc;
                  state   <= FETCH;
               end
            end
            DRAIN: begin
               if (bus.imem_rvalid) begin
                  addr_q <= next_pc;
                  state  <= FETCH;
               end
            end
            default: begin
               state <= FETCH;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.if_valid  = valid_q;
   assign bus.if_instr  = instr_q;
   assign bus.if_pc     = if_pc_q;
   assign bus.if_opcode = instr_q[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: two instances (RESET_PC 0 and 0xFFFF_FFFC)
// driven by a behavioural memory with programmable response latency.
module tb_fetch_unit;
   import fetch_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   lat = 0;
   int   cnt1 = 0;
   int   cnt2 = 0;

   fetch_if bus ();
   fetch_if bus2 ();

   fetch_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fetch_unit #(
      .RESET_PC (32'hFFFF_FFFC)
   ) dut_wrap (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial begin
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t reached, required finish before 100000", $time);
      $fatal(1);
   end

   function automatic logic [31:0] word_at(input logic [31:0] a);
      case (a)
         32'h0:   word_at = 32'h0000_0033;
         32'h4:   word_at = 32'h0000_0003;
         32'h8:   word_at = NOP;
         default: word_at = {a[23:0], 8'h13};
      endcase
   endfunction

   // Memory: rvalid after 'lat' waiting cycles; a new request starts the cycle after a response.
   initial begin
      bus.imem_rvalid  = 1'b0;
      bus.imem_rdata   = 32'h0;
      bus2.imem_rvalid = 1'b0;
      bus2.imem_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         if (!bus.imem_req) begin
            cnt1 = 0;
            bus.imem_rvalid = 1'b0;
         end else begin
            if (bus.imem_rvalid) cnt1 = 0;
            bus.imem_rvalid = (cnt1 >= lat);
            if (!bus.imem_rvalid) cnt1++;
            bus.imem_rdata = word_at(bus.imem_addr);
         end
         if (!bus2.imem_req) begin
            cnt2 = 0;
            bus2.imem_rvalid = 1'b0;
         end else begin
            if (bus2.imem_rvalid) cnt2 = 0;
            bus2.imem_rvalid = 1'b1;
            bus2.imem_rdata = word_at(bus2.imem_addr);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.if_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      tick();
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.if_valid); end
      checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", bus.if_instr); end
      checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", bus.if_pc); end
      checks++; if (bus2.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req_wrap: got %b want 0", bus2.imem_req); end
      rst = 1'b0;
      tick();
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 0", bus.imem_addr); end
      checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL first_addr_wrap: got %h want fffffffc", bus2.imem_addr); end
   endtask

   task automatic test_basic();
      logic [31:0] exp_pc [2];
      logic [6:0]  exp_op [2];
      exp_pc[0] = 32'h0; exp_op[0] = OP;
      exp_pc[1] = 32'h4; exp_op[1] = LOAD;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL basic_valid%0d: got %b want 1", i, bus.if_valid); end
         checks++; if (bus.if_pc !== exp_pc[i]) begin errors++; $display("FAIL basic_pc%0d: got %h want %h", i, bus.if_pc, exp_pc[i]); end
         checks++; if (bus.if_opcode !== exp_op[i]) begin errors++; $display("FAIL basic_op%0d: got %b want %b", i, bus.if_opcode, exp_op[i]); end
         checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL basic_hold_req%0d: got %b want 0", i, bus.imem_req); end
         tick();
         checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL basic_gap%0d: got %b want 0", i, bus.if_valid); end
         checks++; if (bus.imem_addr !== exp_pc[i] + 32'd4) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", i, bus.imem_addr, exp_pc[i] + 32'd4); end
      end
   endtask

   task automatic test_stall();
      bus.if_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b want 1", i, bus.if_valid); end
         checks++; if (bus.if_instr !== NOP) begin errors++; $display("FAIL stall_instr%0d: got %h want %h", i, bus.if_instr, NOP); end
         checks++; if (bus.if_pc !== 32'h8) begin errors++; $display("FAIL stall_pc%0d: got %h want 8", i, bus.if_pc); end
         checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d: got %b want 0", i, bus.imem_req); end
      end
      bus.if_ready = 1'b1;
      tick();
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b want 0", bus.if_valid); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin errors++; $display("FAIL stall_release_req: got req=%b addr=%h want req=1 addr=c", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_redirect_drain();
      int n;
      lat = 3;
      do_reset();
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h100;
      tick();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL drain_old_addr: got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
      tick();
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL drain_no_valid: got %b want 0", bus.if_valid); end
      tick();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL drain_new_addr: got req=%b addr=%h want req=1 addr=100", bus.imem_req, bus.imem_addr); end
      n = 0;
      while (!bus.if_valid && n < 20) begin tick(); n++; end
      checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL drain_timeout: got valid=%b want 1 within 20 cycles", bus.if_valid); end
      checks++; if (bus.if_pc !== 32'h100) begin errors++; $display("FAIL drain_first_pc: got %h want 100", bus.if_pc); end
      checks++; if (bus.if_instr !== 32'h0001_0013) begin errors++; $display("FAIL drain_instr: got %h want 00010013", bus.if_instr); end
   endtask

   task automatic test_drain_double();
      int n;
      lat = 3;
      do_reset();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h100;
      tick();
      bus.redirect_pc = 32'h300;
      tick();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL drain2_old_addr: got %h want 0", bus.imem_addr); end
      n = 0;
      while (!bus.if_valid && n < 20) begin tick(); n++; end
      checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL drain2_timeout: got valid=%b want 1 within 20 cycles", bus.if_valid); end
      checks++; if (bus.if_pc !== 32'h300) begin errors++; $display("FAIL drain2_pc: got %h want 300", bus.if_pc); end
   endtask

   task automatic test_redirect_rvalid();
      lat = 0;
      do_reset();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h40;
      tick();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL coinc_no_valid: got %b want 0", bus.if_valid); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL coinc_addr: got req=%b addr=%h want req=1 addr=40", bus.imem_req, bus.imem_addr); end
      tick();
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40) begin errors++; $display("FAIL coinc_pc: got valid=%b pc=%h want valid=1 pc=40", bus.if_valid, bus.if_pc); end
      checks++; if (bus.if_instr !== 32'h0000_4013) begin errors++; $display("FAIL coinc_instr: got %h want 00004013", bus.if_instr); end
   endtask

   task automatic test_redirect_hold();
      lat = 0;
      do_reset();
      tick();
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin errors++; $display("FAIL hold_pre: got valid=%b pc=%h want valid=1 pc=0", bus.if_valid, bus.if_pc); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h203;
      tick();
      bus.redirect_valid = 1'b0;
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL hold_drop: got %b want 0", bus.if_valid); end
      checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL hold_addr: got %h want 200", bus.imem_addr); end
      tick();
      checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200) begin errors++; $display("FAIL hold_next_pc: got valid=%b pc=%h want valid=1 pc=200", bus.if_valid, bus.if_pc); end
   endtask

   task automatic test_wrap();
      do_reset();
      checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h want fffffffc", bus2.imem_addr); end
      tick();
      checks++; if (bus2.if_valid !== 1'b1 || bus2.if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got valid=%b pc=%h want valid=1 pc=fffffffc", bus2.if_valid, bus2.if_pc); end
      tick();
      checks++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got req=%b addr=%h want req=1 addr=0", bus2.imem_req, bus2.imem_addr); end
      tick();
      checks++; if (bus2.if_valid !== 1'b1 || bus2.if_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got valid=%b pc=%h want valid=1 pc=0", bus2.if_valid, bus2.if_pc); end
   endtask

   task automatic test_reset_mid();
      int n;
      lat = 3;
      do_reset();
      tick();
      rst = 1'b1;
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", bus.imem_req); end
      checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.if_valid); end
      tick();
      rst = 1'b0;
      tick();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_restart: got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
      n = 0;
      while (!bus.if_valid && n < 20) begin tick(); n++; end
      checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL midrst_timeout: got valid=%b want 1 within 20 cycles", bus.if_valid); end
      checks++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0000_0033) begin errors++; $display("FAIL midrst_word: got pc=%h instr=%h want pc=0 instr=00000033", bus.if_pc, bus.if_instr); end
   endtask

   initial begin
      bus.if_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus2.if_ready = 1'b1;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc = 32'h0;
      test_reset();
      test_basic();
      test_stall();
      test_redirect_drain();
      test_drain_double();
      test_redirect_rvalid();
      test_redirect_hold();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
